// File: rtl/top_commutation.sv
// Four-step current-direction commutation controller for a 3x3 matrix converter.
// Three independent per-output sequencers drive 18 registered gate signals.
// Optional feature macro: SHORT_LATCH_EN (sticky short fault, cleared only by rst).
module top_commutation #(
    parameter int unsigned STEP_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        short,
    input  logic [2:0]  CurrentSign,
    input  logic [5:0]  DesiredLoad,
    output logic [17:0] Sout
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [1:0] NUL = 2'b00;

    typedef enum logic [2:0] {STEADY, S1, S2, S3, S4} state_t;

    // Place a device pair on the cell of the selected input; NUL places nothing.
    function automatic logic [5:0] place(input logic [1:0] sel, input logic [1:0] pair);
        logic [5:0] r;
        r = 6'b000000;
        case (sel)
            2'b01:   r = {pair, 4'b0000};
            2'b10:   r = {2'b00, pair, 2'b00};
            2'b11:   r = {4'b0000, pair};
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    // Gate pattern of one output group for a given step.
    function automatic logic [5:0] pattern(input state_t st, input logic [1:0] cur,
                                           input logic [1:0] tgt, input logic sg);
        logic [1:0] cond;
        logic [5:0] r;
        cond = sg ? 2'b10 : 2'b01;
        case (st)
            S1:      r = place(cur, cond);
            S2:      r = place(cur, cond) | place(tgt, cond);
            S3:      r = place(tgt, cond);
            S4:      r = place(tgt, 2'b11);
            default: r = place(cur, 2'b11);
        endcase
        return r;
    endfunction

    // Step order within a commutation.
    function automatic state_t next_step(input state_t st);
        state_t r;
        case (st)
            S1:      r = S2;
            S2:      r = S3;
            S3:      r = S4;
            default: r = STEADY;
        endcase
        return r;
    endfunction

    logic kill;

`ifdef SHORT_LATCH_EN
    logic fault_q;

    // Sticky fault flag: set by a sampled short, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (short) begin
            fault_q <= 1'b1;
        end
    end

    assign kill = short | fault_q;
`else
    assign kill = short;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_seq
        localparam int FI = 2 - g;

        state_t           state_q;
        logic [1:0]       cur_q;
        logic [1:0]       tgt_q;
        logic             sg_q;
        logic [CNT_W-1:0] cnt_q;
        logic [5:0]       grp_q;
        logic [1:0]       eff_c;
        logic             sign_c;

        assign eff_c  = start ? DesiredLoad[2*FI +: 2] : NUL;
        assign sign_c = CurrentSign[FI];
        assign Sout[6*FI +: 6] = grp_q;

        // Per-output sequencer; the gate group is registered from the post-edge state.
        always_ff @(posedge clk) begin
            if (rst || kill) begin
                state_q <= STEADY;
                cur_q   <= NUL;
                tgt_q   <= NUL;
                sg_q    <= 1'b0;
                cnt_q   <= '0;
                grp_q   <= 6'b000000;
            end else begin
                case (state_q)
                    STEADY: begin
                        cnt_q <= '0;
                        if (eff_c != cur_q) begin
                            state_q <= S1;
                            tgt_q   <= eff_c;
                            sg_q    <= sign_c;
                            grp_q   <= pattern(S1, cur_q, eff_c, sign_c);
                        end else begin
                            grp_q   <= pattern(STEADY, cur_q, tgt_q, sg_q);
                        end
                    end
                    default: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= next_step(state_q);
                            if (state_q == S4) begin
                                cur_q <= tgt_q;
                                grp_q <= pattern(STEADY, tgt_q, tgt_q, sg_q);
                            end else begin
                                grp_q <= pattern(next_step(state_q), cur_q, tgt_q, sg_q);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_top_commutation.sv
// Directed bench for top_commutation with a short step time.
module tb_top_commutation;

    localparam int unsigned S = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        short;
    logic [2:0]  CurrentSign;
    logic [5:0]  DesiredLoad;
    logic [17:0] Sout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        start;
        logic        short;
        logic [2:0]  sign;
        logic [5:0]  dl;
        int          n;
        logic [17:0] exp;
    } row_t;

    row_t rows[$];

    localparam logic [17:0] ZERO = 18'd0;
    localparam logic [17:0] FULL = {6'b110000, 6'b001100, 6'b000011};
    localparam logic [17:0] HALF = {6'b100000, 6'b001000, 6'b000001};

    top_commutation #(.STEP_CYCLES(S)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .short(short),
        .CurrentSign(CurrentSign),
        .DesiredLoad(DesiredLoad),
        .Sout(Sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic r, input logic st, input logic sh,
                                input logic [2:0] sg, input logic [5:0] dl,
                                input int n, input logic [17:0] exp);
        row_t x;
        x.rst = r; x.start = st; x.short = sh; x.sign = sg; x.dl = dl; x.n = n; x.exp = exp;
        return x;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [17:0] exp);
        checks++;
        if (Sout !== exp) begin
            errors++;
            $display("FAIL %s: Sout=%b expected %b", name, Sout, exp);
        end
    endtask

    task automatic run_row(input string name, input row_t r);
        rst = r.rst; start = r.start; short = r.short;
        CurrentSign = r.sign; DesiredLoad = r.dl;
        tick(r.n);
        check(name, r.exp);
    endtask

    task automatic hs(input string name, input int n, input logic [17:0] exp);
        tick(n);
        check(name, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; short = 1'b0;
        CurrentSign = 3'b000; DesiredLoad = 6'b000000;

        // reset (with short also high: reset wins, no fault latched), idle
        rows.push_back(mk(1, 0, 1, 3'b110, 6'b01_10_11, 1, ZERO));
        rows.push_back(mk(0, 0, 0, 3'b110, 6'b01_10_11, 2, ZERO));
        // NUL -> A/B/C
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, 1, ZERO));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, S-1, ZERO));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, 1, HALF));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, 2*S, FULL));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, S, FULL));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b01_10_11, 1, FULL));
        // A: inA -> inB, sign 1, with step-length checks
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, 1,   {6'b100000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, S-1, {6'b100000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, 1,   {6'b101000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, S-1, {6'b101000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, 1,   {6'b001000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, S-1, {6'b001000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, 1,   {6'b001100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b110, 6'b10_10_11, S,   {6'b001100, 6'b001100, 6'b000011}));
        // A: inB -> inA, sign 0
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b01_10_11, 1, {6'b000100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b01_10_11, S, {6'b010100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b01_10_11, S, {6'b010000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b01_10_11, S, FULL));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b01_10_11, S, FULL));
        // A: inA -> inB, sign 0
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b10_10_11, 1, {6'b010000, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b10_10_11, S, {6'b010100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b10_10_11, S, {6'b000100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b10_10_11, S, {6'b001100, 6'b001100, 6'b000011}));
        rows.push_back(mk(0, 1, 0, 3'b010, 6'b10_10_11, S, {6'b001100, 6'b001100, 6'b000011}));

        foreach (rows[i]) run_row($sformatf("vec%0d", i), rows[i]);

        // Inputs change during S2 are ignored; new target starts on the first STEADY cycle
        DesiredLoad = 6'b01_10_11; CurrentSign = 3'b110;
        hs("s2chg_s1", 1, {6'b001000, 6'b001100, 6'b000011});
        hs("s2chg_s2", S, {6'b101000, 6'b001100, 6'b000011});
        tick(1);
        DesiredLoad = 6'b11_10_11; CurrentSign = 3'b010;
        hs("s2chg_hold", S-2, {6'b101000, 6'b001100, 6'b000011});
        hs("s2chg_s3", 1, {6'b100000, 6'b001100, 6'b000011});
        hs("s2chg_s4", S, FULL);
        hs("s2chg_std", S, FULL);
        hs("new_s1", 1, {6'b010000, 6'b001100, 6'b000011});
        hs("new_s2", S, {6'b010001, 6'b001100, 6'b000011});
        hs("new_s3", S, {6'b000001, 6'b001100, 6'b000011});
        hs("new_s4", S, {6'b000011, 6'b001100, 6'b000011});
        hs("new_std", S, {6'b000011, 6'b001100, 6'b000011});

        // One-cycle short during a running sequence
        DesiredLoad = 6'b01_10_11; CurrentSign = 3'b110;
        hs("sh_s1", 1, {6'b000010, 6'b001100, 6'b000011});
        hs("sh_s1b", 1, {6'b000010, 6'b001100, 6'b000011});
        short = 1'b1;
        hs("sh_kill", 1, ZERO);
        short = 1'b0;
        hs("sh_after", 1, ZERO);
`ifdef SHORT_LATCH_EN
        hs("sh_latched", S, ZERO);
        hs("sh_latched2", 2*S, ZERO);
`else
        hs("sh_recom_s2", S, HALF);
`endif
        // Reset mid-sequence aborts; then a clean restart from NUL
        rst = 1'b1;
        hs("rst_mid", 1, ZERO);
        rst = 1'b0;
        hs("rst_s1", 1, ZERO);
        hs("rst_s2", S, HALF);
        hs("rst_s4", 2*S, FULL);
        hs("rst_std", S, FULL);

        // Deassert start: graceful commutation to off
        start = 1'b0;
        hs("off_s1", 1, HALF);
        hs("off_s1_end", S-1, HALF);
        hs("off_s2", 1, HALF);
        hs("off_s2_end", S-1, HALF);
        hs("off_s3", 1, ZERO);
        hs("off_std", 2*S, ZERO);
        hs("off_hold", 1, ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
